cluster_acc_dispatch: RTL and testbench
=======================================

CLUSTER_ACC_DISPATCH -- requirements
Module: cluster_acc_dispatch

Interface
REQ-001 SHALL have parameter NrClusters, default 4: number of Ara instances served; legal range 2..16.
REQ-002 SHALL have parameter ReqWidth, default 64: request payload width in bits.
REQ-003 SHALL have parameter RespWidth, default 64: response payload width in bits.
REQ-004 SHALL have parameter RespDepth, default 4: entries per per-cluster response FIFO; legal range 2 or more.
REQ-005 SHALL have parameter MaxOutstanding, default 8: in-flight request limit; legal range 2 or more.
REQ-006 SHALL have parameter LeadCluster, default 0: cluster whose data is returned for broadcast responses.
REQ-007 SHALL have ports clk_i in 1 (clock); rst_ni in 1 (reset: one clock, reset synchronous and active-low).
REQ-008 SHALL have ports req_valid_i in 1; req_ready_o out 1; req_data_i in ReqWidth; req_bcast_i in 1 (1 = all clusters); req_dst_i in max(1,$clog2(NrClusters)) (unicast target).
REQ-009 SHALL have ports cl_req_valid_o out NrClusters; cl_req_ready_i in NrClusters; cl_req_data_o out NrClusters x ReqWidth.
REQ-010 SHALL have ports cl_resp_valid_i in NrClusters; cl_resp_ready_o out NrClusters; cl_resp_data_i in NrClusters x RespWidth; cl_resp_err_i in NrClusters.
REQ-011 SHALL have ports resp_valid_o out 1; resp_ready_i in 1; resp_data_o out RespWidth; resp_err_o out 1; outstanding_o out $clog2(MaxOutstanding+1) (in-flight count).

Function
REQ-012 SHALL derive the target mask as all-ones when req_bcast_i=1, else one-hot of req_dst_i.
REQ-013 SHALL drive cl_req_data_o[c] = req_data_i for every c, combinationally.
REQ-014 SHALL drive cl_req_valid_o[c] = req_valid_i AND target[c] AND NOT sent_q[c] AND (outstanding_o < MaxOutstanding).
REQ-015 SHALL set sent_q[c] on each cl_req_valid_o[c] AND cl_req_ready_i[c] handshake while the request is pending.
REQ-016 SHALL assert req_ready_o combinationally in the cycle in which every targeted cluster has either sent_q set or a handshake in that cycle; sent_q SHALL then clear to 0 on the next edge.
REQ-017 SHALL complete a request in zero cycles when all targeted clusters are ready in the first valid cycle; each cluster SHALL receive exactly one handshake per request.
REQ-018 SHALL hold req_ready_o=0 and all cl_req_valid_o=0 while outstanding_o = MaxOutstanding.
REQ-019 SHALL push {bcast, dst} into an order FIFO of depth MaxOutstanding on req_valid_i AND req_ready_o.
REQ-020 SHALL keep one response FIFO per cluster of depth RespDepth; cl_resp_ready_o[c] = NOT full[c]; a push occurs on cl_resp_valid_i[c] AND cl_resp_ready_o[c].
REQ-021 SHALL assert resp_valid_o when the order FIFO is non-empty and every cluster targeted by its head has a non-empty response FIFO; the FIFO outputs are registered, so the earliest resp_valid_o is 1 cycle after the last required response push.
REQ-022 SHALL output, for a broadcast head, resp_data_o = head of FIFO[LeadCluster] and resp_err_o = OR of all FIFO-head error bits.
REQ-023 SHALL output, for a unicast head, resp_data_o and resp_err_o taken from the head of FIFO[dst].
REQ-024 SHALL pop the order head and every targeted response FIFO on resp_valid_o AND resp_ready_i.
REQ-025 SHALL hold resp_data_o and resp_err_o at 0 while resp_valid_o=0.
REQ-026 SHALL update outstanding_o as +1 on request accept and -1 on response pop, with net 0 when both occur in the same cycle.
REQ-027 SHALL allow a push and a pop on a full response FIFO in the same cycle only if cl_resp_ready_o was already high, i.e. ready does not depend on the same-cycle pop.
REQ-028 SHALL NOT block response pushes of non-targeted clusters; those entries wait for their own order entries.

Reset
REQ-029 SHALL, on rst_ni=0 at a clk_i edge, clear sent_q, all FIFOs and the counter; this applies also mid-handshake and discards in-flight responses.
REQ-030 SHALL hold outputs during and after reset until new activity at: req_ready_o=0 (unless gated true by REQ-016), cl_req_valid_o=0, cl_resp_ready_o=all-ones, resp_valid_o=0, resp_data_o=0, resp_err_o=0, outstanding_o=0.

Verification
REQ-031 SHALL verify broadcast with all ready: req_data=0xA5, bcast=1 -> all 4 cl_req_valid_o pulse 1 cycle, req_ready_o=1 same cycle, outstanding_o=1.
REQ-032 SHALL verify staggered ready: clusters ready in cycles 0,2,2,5 -> each cluster sees one handshake only, req_ready_o=1 in cycle 5 only.
REQ-033 SHALL verify response merge: responses 0x11..0x44 arrive from clusters 0..3, cluster 2 err=1, the last in cycle t -> resp_valid_o at t+1, resp_data_o=0x11, resp_err_o=1.
REQ-034 SHALL verify unicast ordering: unicast to cluster 3, then broadcast; cluster 0 responds first -> the first output is cluster 3 data, then merged broadcast data.
REQ-035 SHALL verify the outstanding limit: 8 accepted requests with no responses -> req_ready_o=0 and cl_req_valid_o=0; one pop -> next request accepted, outstanding_o stays 8.
REQ-036 SHALL verify reset mid-operation: rst_ni=0 with sent_q=0b0101 and 3 outstanding -> next cycle all reset values, no response is emitted.

Source files
------------

// File: rtl/cluster_acc_dispatch.sv
// Fans requests out to a set of accelerator clusters (broadcast or unicast) and returns the
// responses in request order, merging broadcast responses into one.
module cluster_acc_dispatch #(
  parameter int NrClusters     = 4,
  parameter int ReqWidth       = 64,
  parameter int RespWidth      = 64,
  parameter int RespDepth      = 4,
  parameter int MaxOutstanding = 8,
  parameter int LeadCluster    = 0,
  localparam int DstWidth      = (NrClusters > 1) ? $clog2(NrClusters) : 1,
  localparam int OutWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [ReqWidth-1:0]                   req_data_i,
  input  logic                                  req_bcast_i,
  input  logic [DstWidth-1:0]                   req_dst_i,
  output logic [NrClusters-1:0]                 cl_req_valid_o,
  input  logic [NrClusters-1:0]                 cl_req_ready_i,
  output logic [NrClusters-1:0][ReqWidth-1:0]   cl_req_data_o,
  input  logic [NrClusters-1:0]                 cl_resp_valid_i,
  output logic [NrClusters-1:0]                 cl_resp_ready_o,
  input  logic [NrClusters-1:0][RespWidth-1:0]  cl_resp_data_i,
  input  logic [NrClusters-1:0]                 cl_resp_err_i,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [RespWidth-1:0]                  resp_data_o,
  output logic                                  resp_err_o,
  output logic [OutWidth-1:0]                   outstanding_o
);

  localparam int OrdPtrW = $clog2(MaxOutstanding);
  localparam int RspPtrW = $clog2(RespDepth);
  localparam int RspCntW = $clog2(RespDepth + 1);
  localparam logic [OutWidth-1:0] MaxOut = OutWidth'(MaxOutstanding);

  logic [NrClusters-1:0] target, head_target, cl_hs, cl_done;
  logic [NrClusters-1:0] sent_reg, sent_next;
  logic [NrClusters-1:0] rsp_nonempty, head_err;
  logic [NrClusters-1:0][RespWidth:0] rsp_head;
  logic [OutWidth-1:0] outstanding_reg, outstanding_next;
  logic [OrdPtrW-1:0] ord_wr_reg, ord_rd_reg;
  logic [DstWidth:0] ord_mem [MaxOutstanding];
  logic head_bcast;
  logic [DstWidth-1:0] head_dst;
  logic can_issue, accept, resp_pop;

  assign can_issue = outstanding_reg < MaxOut;
  assign req_ready_o = can_issue & (&cl_done);
  assign accept = req_valid_i & req_ready_o;
  assign {head_bcast, head_dst} = ord_mem[ord_rd_reg];
  // The order FIFO holds exactly the in-flight requests, so the counter doubles as its fill level.
  assign resp_valid_o = (outstanding_reg != '0) & (&(~head_target | rsp_nonempty));
  assign resp_pop = resp_valid_o & resp_ready_i;
  assign outstanding_o = outstanding_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NrClusters; gi++) begin : g_cluster
      logic [RespWidth:0] mem [RespDepth];
      logic [RspPtrW-1:0] wr_reg, rd_reg;
      logic [RspCntW-1:0] cnt_reg;
      logic push, pop;

      assign target[gi]         = req_bcast_i | (req_dst_i == DstWidth'(gi));
      assign head_target[gi]    = head_bcast | (head_dst == DstWidth'(gi));
      assign cl_req_data_o[gi]  = req_data_i;
      assign cl_req_valid_o[gi] = req_valid_i & target[gi] & ~sent_reg[gi] & can_issue;
      assign cl_hs[gi]          = cl_req_valid_o[gi] & cl_req_ready_i[gi];
      assign cl_done[gi]        = ~target[gi] | sent_reg[gi] | cl_hs[gi];

      // Ready looks only at the current fill level, never at a same-cycle pop.
      assign cl_resp_ready_o[gi] = cnt_reg != RspCntW'(RespDepth);
      assign push             = cl_resp_valid_i[gi] & cl_resp_ready_o[gi];
      assign pop              = resp_pop & head_target[gi];
      assign rsp_nonempty[gi] = cnt_reg != '0;
      assign rsp_head[gi]     = mem[rd_reg];
      assign head_err[gi]     = rsp_head[gi][RespWidth];

      always_ff @(posedge clk_i) begin
        if (push) mem[wr_reg] <= {cl_resp_err_i[gi], cl_resp_data_i[gi]};
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          wr_reg  <= '0;
          rd_reg  <= '0;
          cnt_reg <= '0;
        end else begin
          if (push) wr_reg <= (wr_reg == RspPtrW'(RespDepth - 1)) ? '0 : wr_reg + 1'b1;
          if (pop)  rd_reg <= (rd_reg == RspPtrW'(RespDepth - 1)) ? '0 : rd_reg + 1'b1;
          case ({push, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    sent_next = sent_reg;
    if (accept) sent_next = '0;
    else if (req_valid_i) sent_next = sent_reg | cl_hs;
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({accept, resp_pop})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_comb begin
    resp_data_o = '0;
    resp_err_o  = 1'b0;
    if (resp_valid_o) begin
      if (head_bcast) begin
        resp_data_o = rsp_head[LeadCluster][RespWidth-1:0];
        resp_err_o  = |head_err;
      end else begin
        resp_data_o = rsp_head[head_dst][RespWidth-1:0];
        resp_err_o  = head_err[head_dst];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) ord_mem[ord_wr_reg] <= {req_bcast_i, req_dst_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sent_reg        <= '0;
      outstanding_reg <= '0;
      ord_wr_reg      <= '0;
      ord_rd_reg      <= '0;
    end else begin
      sent_reg        <= sent_next;
      outstanding_reg <= outstanding_next;
      if (accept)   ord_wr_reg <= (ord_wr_reg == OrdPtrW'(MaxOutstanding - 1)) ? '0 : ord_wr_reg + 1'b1;
      if (resp_pop) ord_rd_reg <= (ord_rd_reg == OrdPtrW'(MaxOutstanding - 1)) ? '0 : ord_rd_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_cluster_acc_dispatch.sv
// Directed bench for cluster_acc_dispatch: fan-out, staggered ready, response merge,
// ordering, outstanding limit and mid-operation reset.
module tb_cluster_acc_dispatch;

  logic clk = 1'b0;
  logic rst_ni;
  logic req_valid, req_ready, req_bcast;
  logic [63:0] req_data;
  logic [1:0] req_dst;
  logic [3:0] cl_req_valid, cl_req_ready;
  logic [3:0][63:0] cl_req_data;
  logic [3:0] cl_resp_valid, cl_resp_ready, cl_resp_err;
  logic [3:0][63:0] cl_resp_data;
  logic resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;
  logic [3:0] outstanding;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cluster_acc_dispatch dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_data_i     (req_data),
    .req_bcast_i    (req_bcast),
    .req_dst_i      (req_dst),
    .cl_req_valid_o (cl_req_valid),
    .cl_req_ready_i (cl_req_ready),
    .cl_req_data_o  (cl_req_data),
    .cl_resp_valid_i(cl_resp_valid),
    .cl_resp_ready_o(cl_resp_ready),
    .cl_resp_data_i (cl_resp_data),
    .cl_resp_err_i  (cl_resp_err),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .outstanding_o  (outstanding)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 unit after the rising edge; checks run 1 unit later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid = 1'b0; req_bcast = 1'b0; req_data = '0; req_dst = '0;
    cl_req_ready = '0; cl_resp_valid = '0; cl_resp_err = '0; cl_resp_data = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    settle();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_cl_req_valid", {60'd0, cl_req_valid}, 64'd0);
    check("rst_cl_resp_ready", {60'd0, cl_resp_ready}, 64'hF);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_outstanding", {60'd0, outstanding}, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Broadcast, everyone ready at once
    req_valid = 1'b1; req_bcast = 1'b1; req_data = 64'hA5; cl_req_ready = 4'hF;
    settle();
    check("bc_cl_req_valid", {60'd0, cl_req_valid}, 64'hF);
    check("bc_req_ready", {63'd0, req_ready}, 64'd1);
    check("bc_cl_req_data2", cl_req_data[2], 64'hA5);
    tick();
    req_valid = 1'b0;
    settle();
    check("bc_valid_drop", {60'd0, cl_req_valid}, 64'd0);
    check("bc_outstanding", {60'd0, outstanding}, 64'd1);

    // Staggered ready: clusters become ready in cycles 0, 2, 2, 5 and stay ready
    req_valid = 1'b1; req_data = 64'hB6;
    cl_req_ready = 4'b0001; settle();
    check("stg_c0_valid", {60'd0, cl_req_valid}, 64'hF);
    check("stg_c0_ready", {63'd0, req_ready}, 64'd0);
    tick(); settle();
    check("stg_c1_valid", {60'd0, cl_req_valid}, 64'hE);
    check("stg_c1_ready", {63'd0, req_ready}, 64'd0);
    tick(); cl_req_ready = 4'b0111; settle();
    check("stg_c2_valid", {60'd0, cl_req_valid}, 64'hE);
    check("stg_c2_ready", {63'd0, req_ready}, 64'd0);
    tick(); settle();
    check("stg_c3_valid", {60'd0, cl_req_valid}, 64'h8);
    check("stg_c3_ready", {63'd0, req_ready}, 64'd0);
    tick(); settle();
    check("stg_c4_valid", {60'd0, cl_req_valid}, 64'h8);
    check("stg_c4_ready", {63'd0, req_ready}, 64'd0);
    tick(); cl_req_ready = 4'b1111; settle();
    check("stg_c5_valid", {60'd0, cl_req_valid}, 64'h8);
    check("stg_c5_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0; settle();
    check("stg_outstanding", {60'd0, outstanding}, 64'd2);

    // Response merge for the 0xA5 broadcast; cluster 2 reports an error, arriving last
    cl_resp_valid = 4'b0011; cl_resp_data[0] = 64'h11; cl_resp_data[1] = 64'h22;
    tick();
    cl_resp_valid = 4'b1000; cl_resp_data[3] = 64'h44;
    tick();
    cl_resp_valid = 4'b0100; cl_resp_data[2] = 64'h33; cl_resp_err = 4'b0100;
    settle();
    check("mrg_not_yet", {63'd0, resp_valid}, 64'd0);
    tick();
    cl_resp_valid = '0; cl_resp_err = '0;
    settle();
    check("mrg_valid", {63'd0, resp_valid}, 64'd1);
    check("mrg_data", resp_data, 64'h11);
    check("mrg_err", {63'd0, resp_err}, 64'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; settle();
    check("mrg_outstanding", {60'd0, outstanding}, 64'd1);
    check("mrg_popped", {63'd0, resp_valid}, 64'd0);
    // Responses for the 0xB6 broadcast, all in one cycle
    cl_resp_valid = 4'hF;
    cl_resp_data[0] = 64'h55; cl_resp_data[1] = 64'h66; cl_resp_data[2] = 64'h77; cl_resp_data[3] = 64'h88;
    settle();
    check("mrg2_not_yet", {63'd0, resp_valid}, 64'd0);
    tick();
    cl_resp_valid = '0; settle();
    check("mrg2_valid", {63'd0, resp_valid}, 64'd1);
    check("mrg2_data", resp_data, 64'h55);
    check("mrg2_err", {63'd0, resp_err}, 64'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; settle();
    check("mrg2_outstanding", {60'd0, outstanding}, 64'd0);
    check("mrg2_idle_data", resp_data, 64'd0);

    // Unicast to cluster 3, then broadcast; cluster 0 answers first
    req_valid = 1'b1; req_bcast = 1'b0; req_dst = 2'd3; req_data = 64'hC3; settle();
    check("uni_cl_req_valid", {60'd0, cl_req_valid}, 64'h8);
    check("uni_req_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_bcast = 1'b1; req_data = 64'hD4; settle();
    check("uni_bc_cl_req_valid", {60'd0, cl_req_valid}, 64'hF);
    tick();
    req_valid = 1'b0;
    cl_resp_valid = 4'b0001; cl_resp_data[0] = 64'hA0;
    tick();
    cl_resp_valid = '0; settle();
    check("ord_wait_c3", {63'd0, resp_valid}, 64'd0);
    cl_resp_valid = 4'b1000; cl_resp_data[3] = 64'hB3;
    tick();
    cl_resp_valid = '0; settle();
    check("ord_uni_valid", {63'd0, resp_valid}, 64'd1);
    check("ord_uni_data", resp_data, 64'hB3);
    check("ord_uni_err", {63'd0, resp_err}, 64'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; settle();
    check("ord_bc_wait", {63'd0, resp_valid}, 64'd0);
    cl_resp_valid = 4'b1110; cl_resp_err = 4'b0010;
    cl_resp_data[1] = 64'hA1; cl_resp_data[2] = 64'hA2; cl_resp_data[3] = 64'hA3;
    tick();
    cl_resp_valid = '0; cl_resp_err = '0; settle();
    check("ord_bc_valid", {63'd0, resp_valid}, 64'd1);
    check("ord_bc_data", resp_data, 64'hA0);
    check("ord_bc_err", {63'd0, resp_err}, 64'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; settle();
    check("ord_outstanding", {60'd0, outstanding}, 64'd0);

    // Outstanding limit: eight unicasts to cluster 1 with no responses
    req_valid = 1'b1; req_bcast = 1'b0; req_dst = 2'd1;
    for (int i = 0; i < 8; i++) begin
      req_data = 64'(i); settle();
      check("lim_accept", {63'd0, req_ready}, 64'd1);
      tick();
    end
    settle();
    check("lim_blocked_ready", {63'd0, req_ready}, 64'd0);
    check("lim_blocked_valid", {60'd0, cl_req_valid}, 64'd0);
    check("lim_outstanding8", {60'd0, outstanding}, 64'd8);
    cl_resp_valid = 4'b0010; cl_resp_data[1] = 64'h99;
    tick();
    cl_resp_valid = '0; settle();
    check("lim_resp_data", resp_data, 64'h99);
    check("lim_still_blocked", {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; settle();
    check("lim_outstanding7", {60'd0, outstanding}, 64'd7);
    check("lim_reopen", {63'd0, req_ready}, 64'd1);
    tick();
    settle();
    check("lim_outstanding_back8", {60'd0, outstanding}, 64'd8);
    check("lim_closed_again", {63'd0, req_ready}, 64'd0);

    // Mid-operation reset with three in flight and sent = 0101
    req_valid = 1'b0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    req_valid = 1'b1; req_bcast = 1'b0; req_dst = 2'd2; cl_req_ready = 4'hF;
    tick(); tick(); tick();
    req_bcast = 1'b1; cl_req_ready = 4'b0101; settle();
    check("rst2_pre_ready", {63'd0, req_ready}, 64'd0);
    tick(); settle();
    check("rst2_sent_mask", {60'd0, cl_req_valid}, 64'hA);
    check("rst2_outstanding3", {60'd0, outstanding}, 64'd3);
    rst_ni = 1'b0; cl_req_ready = '0;
    cl_resp_valid = 4'b0100; cl_resp_data[2] = 64'h77;
    tick();
    req_valid = 1'b0; cl_resp_valid = '0; settle();
    check("rst2_outstanding", {60'd0, outstanding}, 64'd0);
    check("rst2_cl_req_valid", {60'd0, cl_req_valid}, 64'd0);
    check("rst2_cl_resp_ready", {60'd0, cl_resp_ready}, 64'hF);
    check("rst2_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst2_resp_data", resp_data, 64'd0);
    rst_ni = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst2_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    resp_ready = 1'b0;
    req_valid = 1'b1; req_bcast = 1'b1; req_data = 64'hE7; cl_req_ready = 4'hF; settle();
    check("rst2_fresh_valid", {60'd0, cl_req_valid}, 64'hF);
    check("rst2_fresh_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0; settle();
    check("rst2_fresh_outstanding", {60'd0, outstanding}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
